alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Command-side initiator for the 8-bit ALU. It accepts operation requests (opcode, A, B) over a valid/ready command port and buffers them in a small FIFO. It issues each request to the ALU's A/B/Sel inputs, waits the ALU's registered latency, then captures Out/Zero and returns them over a valid/ready response port. It sits between the control logic and the ALU, and keeps the ALU parked on the hold opcode whenever no operation is in flight.

## Interface
- FIFO_DEPTH, 4: command FIFO entries; power of two, ≥2.
- ALU_LAT, 2: clock edges from the issue edge to the capture edge; ≥2.
- Clk  in  1  single clock, all logic on posedge.
- Rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  request present.
- cmd_ready  out  1  `!full && !Rst`.
- cmd_op  in  4  opcode: 0010 ADD, 0110 SUB, 0000 AND, 0001 OR; all others are illegal.
- cmd_a, cmd_b  in  8  operands.
- alu_a, alu_b  out  8  registered operands to the ALU.
- alu_sel  out  4  registered opcode to the ALU; 4'b1111 (hold) when idle.
- alu_out  in  8  ALU result.
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts.
- rsp_data  out  8  captured result.
- rsp_zero  out  1  captured zero flag.
- rsp_err  out  1  illegal opcode; no ALU access was made.
- busy  out  1  high in any state other than IDLE, or when the FIFO is non-empty.

## Operation
- **Command push:** on `cmd_valid && cmd_ready`. When full, cmd_ready is low; there is no same-cycle pop bypass.
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If the FIFO is non-empty, pop the head.
  - Legal opcode: load alu_a, alu_b and alu_sel from the popped entry; next state ISSUE.
  - Illegal opcode: load rsp_data=0, rsp_zero=0, rsp_err=1, rsp_valid=1; alu_sel stays 1111; next state RESP.
- **ISSUE:** one cycle. At its end, alu_sel returns to 1111; alu_a and alu_b are held. Next state WAIT; the latency counter is loaded with ALU_LAT-2.
- **WAIT:** decrement the counter. At zero, capture alu_out into rsp_data and alu_zero into rsp_zero, clear rsp_err, set rsp_valid; next state RESP.
- **RESP:**
  - rsp_valid and all rsp_* fields are held stable until `rsp_valid && rsp_ready`.
  - On that handshake: clear rsp_valid; next state IDLE.
- **Arithmetic:** the sequencer performs none. Results are modulo-256 as produced by the ALU; the sequencer only transports them.
- **FIFO and responses:** the FIFO keeps accepting while an operation is in flight. Responses leave in command order.

## Timing
- **Reset values** (applied at any Rst edge, including mid-operation):
  - State IDLE; FIFO emptied.
  - alu_a=0, alu_b=0, alu_sel=4'b1111.
  - rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_err=0.
  - busy=0; cmd_ready=0 while Rst is high.
- **Reset mid-operation:** an in-flight operation is discarded and no response is produced. The ALU has no reset; parking it on hold is sufficient.
- **Legal op latency:** pop at edge e0, ALU samples at e1, capture at e0+ALU_LAT. rsp_valid is high after e0+ALU_LAT.
- **Illegal op latency:** rsp_valid is high after e0.
- **Throughput with rsp_ready tied high:**
  - Legal ops: one pop every ALU_LAT+2 cycles.
  - Illegal ops: one pop every 2 cycles.
- **Back-pressure:** with rsp_ready low, the FSM stalls in RESP. The FIFO fills to FIFO_DEPTH behind the stalled entry, so FIFO_DEPTH+1 commands are accepted in total.
- **Simultaneous push and pop** on a non-full FIFO are both performed; occupancy is unchanged.
- **Pointers** wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit.

## Structure
- Shared package alu_pkg holds:
  - opcode constants OP_ADD=4'b0010, OP_SUB=4'b0110, OP_AND=4'b0000, OP_OR=4'b0001, OP_HOLD=4'b1111;
  - an is-legal-opcode function;
  - the FSM state encoding.
- Sub-module alu_cmd_fifo: width 20 (op+a+b), depth FIFO_DEPTH, synchronous reset, push/pop/full/empty.
- Top-level: FSM, latency counter, output registers.

## Test plan
- ADD a=8'h05 b=8'h03, rsp_ready=1 → alu_sel=0010 for one cycle; after edge e0+2: rsp_data=8'h08, rsp_zero=0, rsp_err=0.
- SUB 8'h10−8'h10, then ADD 8'hFF+8'h01 → both return rsp_data=8'h00, rsp_zero=1. Then SUB 8'h00−8'h01 → rsp_data=8'hFF, rsp_zero=0. Responses arrive in order with 4-cycle spacing.
- Illegal op 4'b0111 → rsp_err=1, rsp_data=0; alu_sel never leaves 1111; response after one edge.
- rsp_ready=0, push 6 commands back-to-back → 5 accepted, cmd_ready low from the 6th onward. Releasing rsp_ready drains all 5 in order with correct AND/OR results (e.g. 8'hF0&8'h3C=8'h30, 8'hF0|8'h0F=8'hFF).
- Hold rsp_ready=0 with a response pending → rsp_data, rsp_zero and rsp_err do not change across 10 cycles.
- Assert Rst during WAIT with 3 commands queued → next cycle: rsp_valid=0, alu_sel=1111, busy=0; no response appears afterward. A fresh ADD 8'h01+8'h01 then returns 8'h02.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer.
//   - ALU opcode constants, including the hold opcode used to park the ALU
//   - is_legal_op(): true for the four opcodes the ALU implements
//   - FSM state encoding of the sequencer
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_HOLD = 4'b1111;

  // FIFO entry layout: {op[3:0], a[7:0], b[7:0]}
  localparam int unsigned CMD_W = 20;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } seq_state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO holding queued ALU commands.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset (empties the FIFO)
//   push_i, wdata_i   write request and data; ignored when full
//   pop_i             read request; ignored when empty
//   rdata_o           head entry (valid while !empty_o)
//   full_o, empty_o   status; distinguished by the extra pointer bit
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned Width = CMD_W,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] PtrOne = {{AddrW{1'b0}}, 1'b1};

  logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i && !full_o) begin
      mem_d[wr_ptr_q[AddrW-1:0]] = wdata_i;
      wr_ptr_d                   = wr_ptr_q + PtrOne;
    end
    if (pop_i && !empty_o) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command-side initiator for the 8-bit ALU. Buffers (op, a, b) requests in a
// FIFO, issues each to the ALU for one cycle, waits out the ALU latency,
// captures Out/Zero and returns them over a valid/ready response port.
// Illegal opcodes are answered with rsp_err without touching the ALU.
// Ports:
//   Clk, Rst                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake; cmd_op, cmd_a, cmd_b payload
//   alu_a, alu_b, alu_sel       registered ALU inputs; alu_sel parks on hold
//   alu_out, alu_zero           ALU result inputs
//   rsp_valid/rsp_ready         response handshake; rsp_data, rsp_zero, rsp_err
//   busy                        FSM not idle or commands still queued
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ALU_LAT    = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic       alu_zero,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_zero,
  output logic       rsp_err,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(ALU_LAT);
  localparam logic [CntW-1:0] CntLoad = CntW'(ALU_LAT - 2);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  seq_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      alu_a_q, alu_a_d;
  logic [7:0]      alu_b_q, alu_b_d;
  logic [3:0]      alu_sel_q, alu_sel_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic            rsp_zero_q, rsp_zero_d;
  logic            rsp_err_q, rsp_err_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] fifo_rdata;
  logic [3:0]       head_op;
  logic [7:0]       head_a;
  logic [7:0]       head_b;

  assign cmd_ready = !fifo_full && !Rst;
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_pop  = (state_q == StIdle) && !fifo_empty;

  assign head_op = fifo_rdata[19:16];
  assign head_a  = fifo_rdata[15:8];
  assign head_b  = fifo_rdata[7:0];

  alu_cmd_fifo #(
    .Width (CMD_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_i   (Rst),
    .push_i  (fifo_push),
    .wdata_i ({cmd_op, cmd_a, cmd_b}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          if (is_legal_op(head_op)) begin
            alu_a_d   = head_a;
            alu_b_d   = head_b;
            alu_sel_d = head_op;
            state_d   = StIssue;
          end else begin
            rsp_data_d  = 8'h00;
            rsp_zero_d  = 1'b0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = StResp;
          end
        end
      end
      StIssue: begin
        // ALU samples the opcode on this edge; park it again right after.
        alu_sel_d = OP_HOLD;
        cnt_d     = CntLoad;
        state_d   = StWait;
      end
      StWait: begin
        if (cnt_q == '0) begin
          rsp_data_d  = alu_out;
          rsp_zero_d  = alu_zero;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      alu_a_q     <= 8'h00;
      alu_b_q     <= 8'h00;
      alu_sel_q   <= OP_HOLD;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small registered ALU model.
module tb_alu_cmd_sequencer;

  logic       Clk;
  logic       Rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_zero;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_zero;
  logic       rsp_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  alu_cmd_sequencer #(
    .FIFO_DEPTH (4),
    .ALU_LAT    (2)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // ALU model: registers its result one edge after sampling A/B/Sel, holds otherwise.
  logic [7:0] alu_res = 8'h00;
  always @(posedge Clk) begin
    case (alu_sel)
      4'b0010: alu_res <= alu_a + alu_b;
      4'b0110: alu_res <= alu_a - alu_b;
      4'b0000: alu_res <= alu_a & alu_b;
      4'b0001: alu_res <= alu_a | alu_b;
      default: alu_res <= alu_res;
    endcase
  end
  assign alu_out  = alu_res;
  assign alu_zero = (alu_res == 8'h00);

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_a = 8'h00; cmd_b = 8'h00;
    rsp_ready = 1'b0;
    tick(); tick();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (alu_sel !== 4'b1111) begin failures++; $display("FAIL reset_alu_sel got=%b exp=1111", alu_sel); end
    checks++; if ({alu_a, alu_b} !== 16'h0000) begin failures++; $display("FAIL reset_alu_ab got=%h exp=0000", {alu_a, alu_b}); end
    checks++; if ({rsp_data, rsp_zero, rsp_err} !== 10'h000) begin failures++; $display("FAIL reset_rsp_fields got=%h exp=000", {rsp_data, rsp_zero, rsp_err}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
    Rst = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL post_reset_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_add();
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 4'b0010; cmd_a = 8'h05; cmd_b = 8'h03;
    tick();
    cmd_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL add_busy_queued got=%b exp=1", busy); end
    tick(); // e0: pop
    checks++; if (alu_sel !== 4'b0010) begin failures++; $display("FAIL add_issue_sel got=%b exp=0010", alu_sel); end
    checks++; if ({alu_a, alu_b} !== 16'h0503) begin failures++; $display("FAIL add_issue_ab got=%h exp=0503", {alu_a, alu_b}); end
    tick(); // e1
    checks++; if (alu_sel !== 4'b1111) begin failures++; $display("FAIL add_sel_parked got=%b exp=1111", alu_sel); end
    checks++; if ({alu_a, alu_b} !== 16'h0503) begin failures++; $display("FAIL add_ab_held got=%h exp=0503", {alu_a, alu_b}); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL add_early_valid got=%b exp=0", rsp_valid); end
    tick(); // e0+2: capture
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL add_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if ({rsp_data, rsp_zero, rsp_err} !== {8'h08, 1'b0, 1'b0}) begin
      failures++; $display("FAIL add_rsp got=%h/%b/%b exp=08/0/0", rsp_data, rsp_zero, rsp_err);
    end
    tick();
    checks++; if ({rsp_valid, busy} !== 2'b00) begin failures++; $display("FAIL add_done got=%b exp=00", {rsp_valid, busy}); end
  endtask

  task automatic test_zero_order();
    logic [3:0] ops [3] = '{4'b0110, 4'b0010, 4'b0110};
    logic [7:0] as  [3] = '{8'h10, 8'hFF, 8'h00};
    logic [7:0] bs  [3] = '{8'h10, 8'h01, 8'h01};
    logic [7:0] exd [3] = '{8'h00, 8'h00, 8'hFF};
    logic       exz [3] = '{1'b1, 1'b1, 1'b0};
    int n = 0;
    int t0 = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_op = ops[i]; cmd_a = as[i]; cmd_b = bs[i];
      tick();
    end
    cmd_valid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (rsp_valid && n < 3) begin
        checks++; if ({rsp_data, rsp_zero, rsp_err} !== {exd[n], exz[n], 1'b0}) begin
          failures++; $display("FAIL order_rsp%0d got=%h/%b/%b exp=%h/%b/0", n, rsp_data, rsp_zero, rsp_err, exd[n], exz[n]);
        end
        if (n > 0) begin
          checks++; if (cyc - t0 !== 4) begin failures++; $display("FAIL order_spacing%0d got=%0d exp=4", n, cyc - t0); end
        end
        t0 = cyc;
        n++;
      end
      tick();
    end
    checks++; if (n !== 3) begin failures++; $display("FAIL order_count got=%0d exp=3", n); end
  endtask

  task automatic test_illegal();
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 4'b0111; cmd_a = 8'hAA; cmd_b = 8'h55;
    tick();
    cmd_valid = 1'b0;
    checks++; if (alu_sel !== 4'b1111) begin failures++; $display("FAIL ill_sel_pre got=%b exp=1111", alu_sel); end
    tick(); // e0
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL ill_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if ({rsp_data, rsp_zero, rsp_err} !== {8'h00, 1'b0, 1'b1}) begin
      failures++; $display("FAIL ill_rsp got=%h/%b/%b exp=00/0/1", rsp_data, rsp_zero, rsp_err);
    end
    checks++; if (alu_sel !== 4'b1111) begin failures++; $display("FAIL ill_sel got=%b exp=1111", alu_sel); end
    rsp_ready = 1'b1;
    tick();
    checks++; if ({rsp_valid, busy, alu_sel} !== 6'b001111) begin
      failures++; $display("FAIL ill_done got=%b exp=001111", {rsp_valid, busy, alu_sel});
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b0110, 4'b0001};
    logic [7:0] as  [6] = '{8'hF0, 8'hF0, 8'h11, 8'h0F, 8'h80, 8'h55};
    logic [7:0] bs  [6] = '{8'h3C, 8'h0F, 8'h22, 8'hF0, 8'h01, 8'hAA};
    logic [7:0] exd [5] = '{8'h30, 8'hFF, 8'h33, 8'h00, 8'h7F};
    logic       exz [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int acc = 0;
    int n = 0;
    logic ready6 = 1'b1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1; cmd_op = ops[i]; cmd_a = as[i]; cmd_b = bs[i];
      if (cmd_ready) acc++;
      if (i == 5) ready6 = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    checks++; if (acc !== 5) begin failures++; $display("FAIL bp_accepted got=%0d exp=5", acc); end
    checks++; if (ready6 !== 1'b0) begin failures++; $display("FAIL bp_ready6 got=%b exp=0", ready6); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%b exp=0", cmd_ready); end
    for (int c = 0; c < 10; c++) begin
      checks++; if ({rsp_valid, rsp_data, rsp_zero, rsp_err} !== {1'b1, 8'h30, 1'b0, 1'b0}) begin
        failures++; $display("FAIL bp_hold%0d got=%b/%h/%b/%b exp=1/30/0/0", c, rsp_valid, rsp_data, rsp_zero, rsp_err);
      end
      tick();
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (rsp_valid) begin
        if (n < 5) begin
          checks++; if ({rsp_data, rsp_zero, rsp_err} !== {exd[n], exz[n], 1'b0}) begin
            failures++; $display("FAIL bp_rsp%0d got=%h/%b/%b exp=%h/%b/0", n, rsp_data, rsp_zero, rsp_err, exd[n], exz[n]);
          end
        end
        n++;
      end
      tick();
    end
    checks++; if (n !== 5) begin failures++; $display("FAIL bp_count got=%0d exp=5", n); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_idle got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    bit got = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_op = 4'b0010; cmd_a = 8'(i + 1); cmd_b = 8'(i + 1);
      tick();
    end
    cmd_valid = 1'b0;
    tick(); // second command popped
    tick(); // now in WAIT with three commands queued
    checks++; if ({busy, alu_sel} !== 5'b11111) begin failures++; $display("FAIL mid_wait got=%b exp=11111", {busy, alu_sel}); end
    Rst = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL mid_cmd_ready got=%b exp=0", cmd_ready); end
    tick();
    checks++; if ({rsp_valid, alu_sel, busy} !== 6'b011110) begin
      failures++; $display("FAIL mid_after_rst got=%b exp=011110", {rsp_valid, alu_sel, busy});
    end
    Rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (rsp_valid || busy) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL mid_no_rsp got=%0d exp=0", seen); end
    cmd_valid = 1'b1; cmd_op = 4'b0010; cmd_a = 8'h01; cmd_b = 8'h01;
    tick();
    cmd_valid = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (rsp_valid) begin
        got = 1'b1;
        checks++; if ({rsp_data, rsp_zero, rsp_err} !== {8'h02, 1'b0, 1'b0}) begin
          failures++; $display("FAIL mid_fresh got=%h/%b/%b exp=02/0/0", rsp_data, rsp_zero, rsp_err);
        end
      end
    end
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL mid_fresh_timeout got=%b exp=1", got); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_zero_order();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
